// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: IF/ID inputs, writeback/forwarding sources and the ID/EX register outputs.
// slave is the decode stage's view; master is the view of whatever drives it.
interface decode_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] if_pc;
  logic [31:0]     if_inst;
  logic [2:0]      imm_sel;
  logic [7:0]      ctrl_in;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [1:0]      fwd1;
  logic [1:0]      fwd2;
  logic [XLEN-1:0] ex_alu_out;
  logic [XLEN-1:0] mem_alu_out;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_m2r;
  logic            flush;
  logic            ex_ready;
  logic            br_taken;
  logic [XLEN-1:0] pc_branch;
  logic            ex_valid;
  logic [6:0]      ex_ctrl;
  logic [XLEN-1:0] ex_data1;
  logic [XLEN-1:0] ex_data2;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [3:0]      ex_func;
  logic [XLEN-1:0] ex_imm;

  modport slave (
    input  if_valid, if_pc, if_inst, imm_sel, ctrl_in, wb_we, wb_rd, wb_data,
           fwd1, fwd2, ex_alu_out, mem_alu_out, mem_rdata, mem_m2r, flush, ex_ready,
    output id_ready, br_taken, pc_branch, ex_valid, ex_ctrl, ex_data1, ex_data2,
           ex_rs1, ex_rs2, ex_rd, ex_func, ex_imm
  );

  modport master (
    output if_valid, if_pc, if_inst, imm_sel, ctrl_in, wb_we, wb_rd, wb_data,
           fwd1, fwd2, ex_alu_out, mem_alu_out, mem_rdata, mem_m2r, flush, ex_ready,
    input  id_ready, br_taken, pc_branch, ex_valid, ex_ctrl, ex_data1, ex_data2,
           ex_rs1, ex_rs2, ex_rd, ex_func, ex_imm
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// RV32/RV64 decode stage: register file, immediate generator, forwarded branch resolver,
// load-use interlock and a valid/ready ID/EX register with flush.
module decode_stage_pipe #(
  parameter int XLEN        = 32,
  parameter int NREGS       = 32,
  parameter int RF_INIT_IDX = 0,
  parameter int WB_BYPASS   = 1
) (
  input logic                clk,
  input logic                reset_n,
  decode_stage_pipe_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_BUBBLE = 1'b1
  } ilk_state_e;

  localparam logic [5:0] NREGS_L = 6'(NREGS);

  logic [4:0]      rs1_s;
  logic [4:0]      rs2_s;
  logic [4:0]      rd_s;
  logic [2:0]      funct3_s;
  logic            wr_en_s;
  logic [XLEN-1:0] rf_r [32];
  logic [XLEN-1:0] rf_rd1_s;
  logic [XLEN-1:0] rf_rd2_s;
  logic [31:0]     imm32_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] mem_fwd_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;
  logic            cond_s;
  logic            use_rs2_s;
  logic            raw_hazard_s;
  logic            load_hazard_s;
  logic            ex_adv_s;
  logic            id_ready_s;
  ilk_state_e      state_r;
  ilk_state_e      state_nxt_s;
  logic            ex_valid_r;
  logic [6:0]      ex_ctrl_r;
  logic [XLEN-1:0] ex_data1_r;
  logic [XLEN-1:0] ex_data2_r;
  logic [4:0]      ex_rs1_r;
  logic [4:0]      ex_rs2_r;
  logic [4:0]      ex_rd_r;
  logic [3:0]      ex_func_r;
  logic [XLEN-1:0] ex_imm_r;
  logic            unused_opcode_s;

  function automatic logic idx_ok(input logic [4:0] idx);
    return ({1'b0, idx} < NREGS_L) && (idx != 5'd0);
  endfunction

  function automatic logic [XLEN-1:0] rf_init(input int idx);
    if ((RF_INIT_IDX != 0) && (idx < NREGS)) begin
      return XLEN'(idx);
    end else begin
      return {XLEN{1'b0}};
    end
  endfunction

  assign rs1_s           = bus.if_inst[19:15];
  assign rs2_s           = bus.if_inst[24:20];
  assign rd_s            = bus.if_inst[11:7];
  assign funct3_s        = bus.if_inst[14:12];
  assign unused_opcode_s = ^bus.if_inst[6:0];
  assign wr_en_s         = bus.wb_we && idx_ok(bus.wb_rd);

  // Register file write port; x0 and out-of-range entries are never written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= rf_init(i);
      end
    end else if (wr_en_s) begin
      rf_r[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Register file read ports with optional same-cycle writeback bypass.
  always_comb begin
    rf_rd1_s = {XLEN{1'b0}};
    rf_rd2_s = {XLEN{1'b0}};
    if (idx_ok(rs1_s)) begin
      if ((WB_BYPASS != 0) && wr_en_s && (bus.wb_rd == rs1_s)) begin
        rf_rd1_s = bus.wb_data;
      end else begin
        rf_rd1_s = rf_r[rs1_s];
      end
    end else begin
      rf_rd1_s = {XLEN{1'b0}};
    end
    if (idx_ok(rs2_s)) begin
      if ((WB_BYPASS != 0) && wr_en_s && (bus.wb_rd == rs2_s)) begin
        rf_rd2_s = bus.wb_data;
      end else begin
        rf_rd2_s = rf_r[rs2_s];
      end
    end else begin
      rf_rd2_s = {XLEN{1'b0}};
    end
  end

  // Immediate generator: build a 32-bit sign-extended value, then widen from bit 31.
  always_comb begin
    imm32_s = 32'd0;
    case (bus.imm_sel)
      3'd2:    imm32_s = {{20{bus.if_inst[31]}}, bus.if_inst[31:20]};
      3'd3:    imm32_s = {{20{bus.if_inst[31]}}, bus.if_inst[31:25], bus.if_inst[11:7]};
      3'd4:    imm32_s = {{19{bus.if_inst[31]}}, bus.if_inst[31], bus.if_inst[7],
                          bus.if_inst[30:25], bus.if_inst[11:8], 1'b0};
      3'd5:    imm32_s = {{11{bus.if_inst[31]}}, bus.if_inst[31], bus.if_inst[19:12],
                          bus.if_inst[20], bus.if_inst[30:21], 1'b0};
      3'd6:    imm32_s = {bus.if_inst[31:12], 12'd0};
      default: imm32_s = 32'd0;
    endcase
    imm_s        = {XLEN{imm32_s[31]}};
    imm_s[31:0]  = imm32_s;
  end

  // Operand forwarding muxes feeding both the comparator and ID/EX.
  always_comb begin
    mem_fwd_s = bus.mem_m2r ? bus.mem_rdata : bus.mem_alu_out;
    case (bus.fwd1)
      2'b01:   op1_s = bus.ex_alu_out;
      2'b10:   op1_s = mem_fwd_s;
      default: op1_s = rf_rd1_s;
    endcase
    case (bus.fwd2)
      2'b01:   op2_s = bus.ex_alu_out;
      2'b10:   op2_s = mem_fwd_s;
      default: op2_s = rf_rd2_s;
    endcase
  end

  // Branch condition from funct3; reserved encodings never take.
  always_comb begin
    case (funct3_s)
      3'b000:  cond_s = (op1_s == op2_s);
      3'b001:  cond_s = (op1_s != op2_s);
      3'b100:  cond_s = ($signed(op1_s) <  $signed(op2_s));
      3'b101:  cond_s = ($signed(op1_s) >= $signed(op2_s));
      3'b110:  cond_s = (op1_s <  op2_s);
      3'b111:  cond_s = (op1_s >= op2_s);
      default: cond_s = 1'b0;
    endcase
  end

  // I- and U-type encodings reuse the rs2 field as immediate bits, so it cannot cause a hazard.
  assign use_rs2_s     = (bus.imm_sel != 3'd2) && (bus.imm_sel != 3'd6);
  assign raw_hazard_s  = bus.if_valid && ex_valid_r && ex_ctrl_r[3] && (ex_rd_r != 5'd0) &&
                         ((ex_rd_r == rs1_s) || (use_rs2_s && (ex_rd_r == rs2_s)));
  assign load_hazard_s = raw_hazard_s && (state_r == ST_IDLE);
  assign ex_adv_s      = bus.ex_ready || !ex_valid_r;
  assign id_ready_s    = ex_adv_s && !load_hazard_s;

  assign bus.id_ready  = id_ready_s;
  assign bus.br_taken  = bus.if_valid && bus.ctrl_in[7] && id_ready_s && !bus.flush && cond_s;
  assign bus.pc_branch = bus.if_pc + imm_s;

  // Interlock state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Interlock next state: one bubble per detected load-use pair.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ex_adv_s && load_hazard_s) begin
          state_nxt_s = ST_BUBBLE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUBBLE: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // ID/EX valid and control: flush beats bubble beats capture beats hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= 7'd0;
    end else if (bus.flush) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= 7'd0;
    end else if (ex_adv_s && load_hazard_s) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= 7'd0;
    end else if (ex_adv_s) begin
      ex_valid_r <= bus.if_valid;
      ex_ctrl_r  <= bus.if_valid ? bus.ctrl_in[6:0] : 7'd0;
    end
  end

  // ID/EX data fields load whenever decode accepts; bubbles and stalls keep them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_data1_r <= {XLEN{1'b0}};
      ex_data2_r <= {XLEN{1'b0}};
      ex_rs1_r   <= 5'd0;
      ex_rs2_r   <= 5'd0;
      ex_rd_r    <= 5'd0;
      ex_func_r  <= 4'd0;
      ex_imm_r   <= {XLEN{1'b0}};
    end else if (id_ready_s) begin
      ex_data1_r <= op1_s;
      ex_data2_r <= op2_s;
      ex_rs1_r   <= rs1_s;
      ex_rs2_r   <= rs2_s;
      ex_rd_r    <= rd_s;
      ex_func_r  <= {bus.if_inst[30], funct3_s};
      ex_imm_r   <= imm_s;
    end
  end

  assign bus.ex_valid = ex_valid_r;
  assign bus.ex_ctrl  = ex_ctrl_r;
  assign bus.ex_data1 = ex_data1_r;
  assign bus.ex_data2 = ex_data2_r;
  assign bus.ex_rs1   = ex_rs1_r;
  assign bus.ex_rs2   = ex_rs2_r;
  assign bus.ex_rd    = ex_rd_r;
  assign bus.ex_func  = ex_func_r;
  assign bus.ex_imm   = ex_imm_r;

endmodule
